serial_subtractor: RTL

- Bit-serial N-bit subtractor computing diff = a - b, LSB first, one full-subtractor step per clock.
- Complements the combinational ripple adder in the ALU datapath: the same one-bit cell arithmetic, run in the subtract direction over time.
- Offers a low-area path for the ALU SUB/CMP ops, using a start/busy/done handshake and registered flags.

---
 rtl/serial_subtractor_if.sv | 25 ++
 rtl/serial_subtractor.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The master side issues operations. The slave side is the subtractor itself.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             overflow;
  logic             zero;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow, overflow, zero
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow, overflow, zero
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, one full-subtractor step per clock, LSB first.
// An operation takes WIDTH shift cycles, and done is then pulsed for one cycle.
// Result and flags are registered. They hold until the final step of the next operation.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input logic                clk,
  input logic                rst_n,
  serial_subtractor_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Borrow out of a single full-subtractor cell computing x - y - bin.
  function automatic logic fs_borrow(input logic x, input logic y, input logic bin);
    fs_borrow = (~x & y) | (~x & bin) | (y & bin);
  endfunction

  state_t           state_r;
  state_t           state_next_s;

  logic [WIDTH-1:0] a_sr_r;
  logic [WIDTH-1:0] b_sr_r;
  logic [WIDTH-1:0] diff_sr_r;
  logic             bor_r;
  logic [CW-1:0]    cnt_r;
  logic             a_msb_r;
  logic             b_msb_r;

  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] diff_r;
  logic             borrow_r;
  logic             overflow_r;
  logic             zero_r;

  logic             accept_s;
  logic             shift_s;
  logic             last_s;
  logic             d_s;
  logic             bor_next_s;
  logic [WIDTH-1:0] diff_step_s;

  // State register; an async reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: start is honoured only from IDLE or DONE.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) state_next_s = ST_SHIFT;
        else           state_next_s = ST_IDLE;
      end
      ST_SHIFT: begin
        if (cnt_r == LAST_CNT) state_next_s = ST_DONE;
        else                   state_next_s = ST_SHIFT;
      end
      ST_DONE: begin
        if (bus.start) state_next_s = ST_SHIFT;
        else           state_next_s = ST_IDLE;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Per-cycle decode and the one-bit subtractor cell applied to the current LSBs.
  always_comb begin
    accept_s    = 1'b0;
    shift_s     = 1'b0;
    last_s      = 1'b0;
    d_s         = a_sr_r[0] ^ b_sr_r[0] ^ bor_r;
    bor_next_s  = fs_borrow(a_sr_r[0], b_sr_r[0], bor_r);
    diff_step_s = {d_s, diff_sr_r[WIDTH-1:1]};
    case (state_r)
      ST_IDLE:  accept_s = bus.start;
      ST_DONE:  accept_s = bus.start;
      ST_SHIFT: begin
        shift_s = 1'b1;
        if (cnt_r == LAST_CNT) last_s = 1'b1;
        else                   last_s = 1'b0;
      end
      default: begin
        accept_s = 1'b0;
        shift_s  = 1'b0;
      end
    endcase
  end

  // Operand shift registers, borrow chain and step counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr_r    <= {WIDTH{1'b0}};
      b_sr_r    <= {WIDTH{1'b0}};
      diff_sr_r <= {WIDTH{1'b0}};
      bor_r     <= 1'b0;
      cnt_r     <= {CW{1'b0}};
      a_msb_r   <= 1'b0;
      b_msb_r   <= 1'b0;
    end else if (accept_s) begin
      a_sr_r    <= bus.a;
      b_sr_r    <= bus.b;
      diff_sr_r <= {WIDTH{1'b0}};
      bor_r     <= 1'b0;
      cnt_r     <= {CW{1'b0}};
      a_msb_r   <= bus.a[WIDTH-1];
      b_msb_r   <= bus.b[WIDTH-1];
    end else if (shift_s) begin
      a_sr_r    <= {1'b0, a_sr_r[WIDTH-1:1]};
      b_sr_r    <= {1'b0, b_sr_r[WIDTH-1:1]};
      diff_sr_r <= diff_step_s;
      bor_r     <= bor_next_s;
      cnt_r     <= cnt_r + ONE_CNT;
    end else begin
      a_sr_r    <= a_sr_r;
      b_sr_r    <= b_sr_r;
      diff_sr_r <= diff_sr_r;
      bor_r     <= bor_r;
      cnt_r     <= cnt_r;
    end
  end

  // Registered handshake and result flags. Results update only on the final bit step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      diff_r     <= {WIDTH{1'b0}};
      borrow_r   <= 1'b0;
      overflow_r <= 1'b0;
      zero_r     <= 1'b0;
    end else begin
      busy_r <= (state_next_s == ST_SHIFT);
      done_r <= (state_next_s == ST_DONE);
      if (last_s) begin
        diff_r     <= diff_step_s;
        borrow_r   <= bor_next_s;
        zero_r     <= (diff_step_s == {WIDTH{1'b0}});
        overflow_r <= (a_msb_r != b_msb_r) && (d_s != a_msb_r);
      end else begin
        diff_r     <= diff_r;
        borrow_r   <= borrow_r;
        zero_r     <= zero_r;
        overflow_r <= overflow_r;
      end
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.diff     = diff_r;
  assign bus.borrow   = borrow_r;
  assign bus.overflow = overflow_r;
  assign bus.zero     = zero_r;

endmodule
